// File: rtl/ncl_instr_injector.sv
// Clocked front end for a dual-rail NCL stage: buffers binary instruction words and
// issues them as DATA/NULL wavefronts paced by the stage's 4-phase acknowledge.
module ncl_instr_injector #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_instr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] instruction,
   input  logic        ack_in,
   input  logic        clr_err,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] tok_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      WAIT_NULL = 2'd2
   } state_t;

   // Pair i carries {true rail, false rail} = {b[i], ~b[i]}.
   function automatic logic [15:0] dual_rail_enc(input logic [7:0] b);
      logic [15:0] w;
      w = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         w[2*i+1] = b[i];
         w[2*i]   = ~b[i];
      end
      return w;
   endfunction

   logic [SYNC_STAGES-1:0] ack_sync_r;
   logic                   ack_s;
   logic [7:0]             mem_r [DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CW-1:0]          count_r;
   logic [CW-1:0]          count_nxt_s;
   logic                   in_ready_r;
   logic                   empty_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   done_s;
   logic                   wait_s;
   logic                   state_chg_s;
   logic                   tmo_hit_s;
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [TW-1:0]          tmo_cnt_r;
   logic [15:0]            instr_r;
   logic [15:0]            tok_count_r;
   logic                   busy_r;
   logic                   err_r;

   assign ack_s       = ack_sync_r[SYNC_STAGES-1];
   assign empty_s     = (count_r == {CW{1'b0}});
   assign push_s      = in_valid && in_ready_r;
   assign wait_s      = (state_r != IDLE) || (!empty_s && ack_s);
   assign state_chg_s = (state_nxt_s != state_r);
   assign tmo_hit_s   = wait_s && !state_chg_s && (tmo_cnt_r == TMO_LAST);

   assign in_ready    = in_ready_r;
   assign instruction = instr_r;
   assign busy        = busy_r;
   assign timeout_err = err_r;
   assign tok_count   = tok_count_r;

   // Acknowledge synchronizer
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_in};
      end
   end

   // Occupancy update from push/pop
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_instr;
      end
   end

   // FIFO pointers, occupancy and ready flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         in_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r    <= count_nxt_s;
         in_ready_r <= (count_nxt_s != FULL_LVL);
      end
   end

   // Wavefront sequencing: next state and pop/complete strobes
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s && !ack_s) begin
               pop_s       = 1'b1;
               state_nxt_s = WAIT_DATA;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_DATA: begin
            if (ack_s) begin
               done_s      = 1'b1;
               state_nxt_s = WAIT_NULL;
            end else begin
               state_nxt_s = WAIT_DATA;
            end
         end
         WAIT_NULL: begin
            if (!ack_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_NULL;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register, dual-rail bus, token counter and busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         instr_r     <= 16'h0000;
         tok_count_r <= 16'h0000;
         busy_r      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (pop_s) begin
            instr_r <= dual_rail_enc(mem_r[rd_ptr_r]);
         end else if (done_s) begin
            instr_r <= 16'h0000;
         end
         if (done_s) begin
            tok_count_r <= tok_count_r + 16'd1;
         end
         busy_r <= (state_nxt_s != IDLE) || (count_nxt_s != {CW{1'b0}});
      end
   end

   // Stall watchdog; a new timeout takes priority over clr_err
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= {TW{1'b0}};
         err_r     <= 1'b0;
      end else begin
         if (state_chg_s) begin
            tmo_cnt_r <= {TW{1'b0}};
         end else if (tmo_hit_s) begin
            tmo_cnt_r <= TMO_MAX;
         end else if (clr_err) begin
            tmo_cnt_r <= {TW{1'b0}};
         end else if (wait_s && (tmo_cnt_r != TMO_MAX)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
         end
         if (tmo_hit_s) begin
            err_r <= 1'b1;
         end else if (clr_err) begin
            err_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ncl_instr_injector.sv
// Self-checking bench for ncl_instr_injector: a queue-based wavefront model is compared
// against the DUT every cycle, with directed scenarios and randomized traffic.
module tb_ncl_instr_injector;

   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int TMO   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_instr;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instruction;
   logic        ack_in;
   logic        clr_err;
   logic        busy;
   logic        timeout_err;
   logic [15:0] tok_count;

   ncl_instr_injector #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .ack_in(ack_in), .clr_err(clr_err), .busy(busy),
      .timeout_err(timeout_err), .tok_count(tok_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Spread each bit onto both rails of its pair, then invert the false rails.
   function automatic logic [15:0] enc(input logic [7:0] b);
      logic [15:0] s;
      s = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) s = s | (16'h0003 << (2*i));
      end
      return s ^ 16'h5555;
   endfunction

   function automatic logic bad_pair(input logic [15:0] w);
      for (int i = 0; i < 8; i++) begin
         if (w[2*i+1] && w[2*i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0]      mq[$];
   int              m_phase = 0;   // 0: free to issue, 1: DATA shown, 2: NULL shown, stage still high
   logic [15:0]     m_bus = 16'h0000;
   logic [15:0]     m_tok = 16'h0000;
   logic            m_err = 1'b0;
   logic            m_ready = 1'b1;
   logic            m_busy = 1'b0;
   int              m_wait = 0;
   logic [SYNC-1:0] m_sync = '0;
   bit              model_on = 1'b0;
   bit              preload_req = 1'b0;

   always @(posedge clk) begin
      logic ack_seen;
      int   occ;
      bit   moved;
      bit   stalled;
      bit   hit;
      ack_seen = m_sync[SYNC-1];
      occ      = mq.size();
      moved    = 1'b0;
      if (rst) begin
         mq.delete();
         m_phase = 0; m_bus = 16'h0000; m_tok = 16'h0000; m_err = 1'b0;
         m_wait = 0; m_sync = '0; m_ready = 1'b1; m_busy = 1'b0;
         model_on = 1'b1;
      end else begin
         if (preload_req) m_tok = 16'hFFFF;
         stalled = (m_phase != 0) || (occ != 0 && ack_seen);
         if (m_phase == 0 && occ > 0 && !ack_seen) begin
            m_bus = enc(mq.pop_front()); m_phase = 1; moved = 1'b1;
         end else if (m_phase == 1 && ack_seen) begin
            m_bus = 16'h0000; m_tok = m_tok + 16'd1; m_phase = 2; moved = 1'b1;
         end else if (m_phase == 2 && !ack_seen) begin
            m_phase = 0; moved = 1'b1;
         end
         if (in_valid && occ < DEPTH) mq.push_back(in_instr);
         hit = !moved && stalled && (m_wait == TMO - 1);
         if (moved)                          m_wait = 0;
         else if (hit)                       m_wait = TMO;
         else if (clr_err)                   m_wait = 0;
         else if (stalled && m_wait < TMO)   m_wait++;
         if (hit)          m_err = 1'b1;
         else if (clr_err) m_err = 1'b0;
         m_sync  = {m_sync[SYNC-2:0], ack_in};
         m_ready = (mq.size() < DEPTH);
         m_busy  = (m_phase != 0) || (mq.size() > 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [15:0] prev_bus = 16'h0000;
   logic [15:0] seen[$];

   always @(negedge clk) begin
      if (model_on) begin
         check("instruction", instruction, m_bus);
         check("in_ready", {15'h0, in_ready}, {15'h0, m_ready});
         check("busy", {15'h0, busy}, {15'h0, m_busy});
         check("tok_count", tok_count, m_tok);
         check("timeout_err", {15'h0, timeout_err}, {15'h0, m_err});
         check("rail_pair", {15'h0, bad_pair(instruction)}, 16'h0000);
         if (prev_bus == 16'h5555 && instruction != 16'h5555)
            check("null_between", instruction, 16'h0000);
         if (prev_bus == 16'h0000 && instruction != 16'h0000) seen.push_back(instruction);
         prev_bus = instruction;
      end
   end

   // ---------------- stage emulator ----------------
   int         ack_mode = 1;   // 0: hold low, 1: echo bus state
   int         ack_dly  = 3;
   logic [3:0] hist = 4'h0;

   initial begin
      ack_in = 1'b0;
      forever begin
         @(negedge clk);
         hist = {hist[2:0], (instruction != 16'h0000)};
         if (ack_mode == 1) ack_in = hist[ack_dly-1];
         else               ack_in = 1'b0;
      end
   end

   task automatic wait_for(input int what, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ((what == 0 && instruction == 16'h0000) || (what == 1 && instruction != 16'h0000) ||
             (what == 2 && !busy)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check(name, {15'h0, ok}, 16'h0001);
   endtask

   task automatic push_one(input logic [7:0] w);
      in_valid = 1'b1; in_instr = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w[6];
      int         acc;
      bit         rdy;
      logic [7:0] x;

      rst = 1'b1; in_valid = 1'b0; in_instr = 8'h00; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_instr", instruction, 16'h0000);
      check("rst_ready", {15'h0, in_ready}, 16'h0001);
      check("rst_busy", {15'h0, busy}, 16'h0000);
      check("rst_tok", tok_count, 16'h0000);
      check("rst_err", {15'h0, timeout_err}, 16'h0000);

      // Single word, stage echoes after 3 cycles
      in_valid = 1'b1; in_instr = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_data", instruction, 16'h9966);
      wait_for(0, "t1_wait_null");
      check("t1_tok", tok_count, 16'h0001);
      wait_for(2, "t1_wait_idle");
      check("t1_busy", {15'h0, busy}, 16'h0000);

      // Back-to-back 00 / FF
      in_valid = 1'b1; in_instr = 8'h00;
      @(negedge clk);
      in_instr = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_for(1, "t2_wait_d0");
      check("t2_first", instruction, 16'h5555);
      wait_for(0, "t2_wait_null");
      wait_for(1, "t2_wait_d1");
      check("t2_second", instruction, 16'hAAAA);
      wait_for(2, "t2_wait_idle");

      // Fill with stage stalled
      ack_mode = 0;
      seen.delete();
      for (int i = 0; i < 6; i++) w[i] = 8'(i * 37 + 11);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_instr = w[acc];
         rdy = in_ready;
         @(negedge clk);
         if (rdy) acc++;
      end
      check("t3_accepted", 16'(acc), 16'd5);
      check("t3_ready_low", {15'h0, in_ready}, 16'h0000);
      check("t3_head_on_bus", instruction, enc(w[0]));
      ack_mode = 1;
      for (int i = 0; i < 100 && acc < 6; i++) begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) acc++;
      end
      in_valid = 1'b0;
      check("t3_sixth", 16'(acc), 16'd6);
      wait_for(2, "t3_wait_idle");
      check("t3_count", 16'(seen.size()), 16'd6);
      for (int i = 0; i < 6 && i < seen.size(); i++) check("t3_order", seen[i], enc(w[i]));

      // Timeout with stage stuck low
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ack_mode = 0;
      push_one(8'h3C);
      @(negedge clk);
      check("t4_data", instruction, enc(8'h3C));
      repeat (15) @(negedge clk);
      check("t4_err_before", {15'h0, timeout_err}, 16'h0000);
      @(negedge clk);
      check("t4_err_set", {15'h0, timeout_err}, 16'h0001);
      check("t4_bus_held", instruction, enc(8'h3C));
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t4_err_clr", {15'h0, timeout_err}, 16'h0000);
      repeat (15) @(negedge clk);
      check("t4_err_before2", {15'h0, timeout_err}, 16'h0000);
      @(negedge clk);
      check("t4_err_reset", {15'h0, timeout_err}, 16'h0001);
      ack_mode = 1;
      wait_for(2, "t4_wait_idle");
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;

      // Reset while DATA is pending and two words are queued
      ack_mode = 0;
      in_valid = 1'b1; in_instr = 8'h11;
      @(negedge clk);
      in_instr = 8'h22;
      @(negedge clk);
      in_instr = 8'h33;
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_pre_busy", {15'h0, busy}, 16'h0001);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_bus", instruction, 16'h0000);
      check("t5_ready", {15'h0, in_ready}, 16'h0001);
      check("t5_busy", {15'h0, busy}, 16'h0000);
      check("t5_tok", tok_count, 16'h0000);
      ack_mode = 1;
      seen.delete();
      repeat (30) @(negedge clk);
      check("t5_no_ghost", 16'(seen.size()), 16'd0);

      // Token counter wrap
      #2;
      force dut.tok_count_r = 16'hFFFF;
      preload_req = 1'b1;
      @(posedge clk);
      #2;
      preload_req = 1'b0;
      release dut.tok_count_r;
      @(negedge clk);
      check("t6_preload", tok_count, 16'hFFFF);
      push_one(8'h5A);
      wait_for(1, "t6_wait_data");
      wait_for(2, "t6_wait_idle");
      check("t6_wrap", tok_count, 16'h0000);
      check("t6_err", {15'h0, timeout_err}, 16'h0000);

      // Randomized traffic
      for (int seg = 0; seg < 6; seg++) begin
         ack_dly = int'($urandom_range(1, 4));
         for (int c = 0; c < 150; c++) begin
            x        = 8'($urandom);
            in_instr = x;
            in_valid = ($urandom_range(0, 2) != 0);
            clr_err  = ($urandom_range(0, 15) == 0);
            @(negedge clk);
         end
         in_valid = 1'b0;
         clr_err  = 1'b0;
         wait_for(2, "rnd_drain");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ncl_instr_injector.md
Name: ncl_instr_injector

Overview:
- Clocked front end that feeds the dual-rail NCL controller stage.
- Accepts 8-bit binary instruction words from the synchronous fetch side through a valid/ready handshake and buffers them in a small FIFO.
- Encodes each word as a 16-bit dual-rail DATA wavefront, alternated with all-zero NULL wavefronts.
- Paces wavefronts with the stage's 4-phase acknowledge (ack high = DATA captured, send NULL; ack low = NULL captured, send DATA).

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the ack synchronizer; minimum 2.
- TIMEOUT, 1024, cycles of waiting for an ack transition before timeout_err is flagged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_instr  in  8  binary instruction word
- in_valid  in  1  in_instr is valid this cycle
- in_ready  out  1  FIFO can accept a word this cycle
- instruction  out  16  dual-rail bus to the stage; pair i = {instruction[2i+1] true rail, instruction[2i] false rail}
- ack_in  in  1  asynchronous completion acknowledge from the stage
- clr_err  in  1  clears timeout_err
- busy  out  1  FSM not IDLE or FIFO non-empty
- timeout_err  out  1  sticky deadlock flag
- tok_count  out  16  count of completed DATA tokens

Behaviour:
- Reset values (edge where rst=1):
  - instruction = 16'h0000 (NULL); in_ready = 1; busy = 0; timeout_err = 0; tok_count = 0.
  - FIFO emptied; synchronizer flops cleared; FSM in IDLE; timeout counter = 0.
- Reset mid-operation: bus returns to NULL on that edge and queued words are discarded. Resetting the asynchronous side (rst_n) at the same time is the system's responsibility.
- ack_in passes through SYNC_STAGES flops to give ack_s. Only ack_s is used internally.
- Encoding: instruction[2i+1] = b[i], instruction[2i] = ~b[i] for i = 0..7.
  - instruction is driven directly from a single register, so all 8 pairs change on the same edge.
  - Never both rails of a pair high. Never a mixed NULL/DATA word.
- FIFO:
  - Push on in_valid && in_ready. in_ready = !full, derived from registered occupancy.
  - At full, in_ready = 0 even if a pop happens in the same cycle.
  - Push and pop may occur in the same cycle when not full.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT_DATA, WAIT_NULL.
  - IDLE: bus is NULL. If FIFO non-empty and ack_s == 0: pop the head, load its encoding into instruction on the same edge, go to WAIT_DATA. A word pushed into an empty FIFO at edge N appears on the bus at edge N+1.
  - WAIT_DATA: hold DATA. When ack_s == 1: instruction <= 0, tok_count++ (wraps 16'hFFFF -> 0), go to WAIT_NULL.
  - WAIT_NULL: hold NULL. When ack_s == 0: go to IDLE. NULL is therefore held at least one cycle after ack_s falls before the next DATA.
- IDLE with ack_s == 1 (stage still busy, or a spurious ack): stay in IDLE and do not pop.
- Timeout:
  - Counter clears on every state change.
  - It increments while in WAIT_DATA, in WAIT_NULL, or in IDLE with FIFO non-empty and ack_s == 1.
  - On reaching TIMEOUT it sets timeout_err and saturates. The FSM keeps waiting; no abort.
  - clr_err clears timeout_err. If clr_err and a new timeout occur in the same cycle, set wins.
- busy = (state != IDLE) || FIFO non-empty; registered.

Test Plan:
1. Reset, push 8'hA5, ack model echoes with 3-cycle delay: bus = 16'h9966 one cycle after the push. After ack rises, bus = 16'h0000, tok_count = 1. After ack falls, FSM returns to IDLE and busy = 0.
2. Push 8'h00 then 8'hFF back-to-back: bus shows 16'h5555, then NULL, then 16'hAAAA. There is never a cycle with 16'h5555 followed directly by 16'hAAAA, and no pair ever reads 2'b11.
3. Hold ack low, push 6 words with DEPTH=4: first word is on the bus, 4 words are queued, in_ready = 0 after the 5th push, and the 6th word is not accepted until a pop. All 5 accepted words later emerge in order.
4. Drive ack_in permanently low after a DATA is on the bus, TIMEOUT=16: timeout_err = 1 exactly 16 cycles after entering WAIT_DATA and the bus still holds DATA. Assert clr_err for one cycle: flag clears, and re-sets after the next timeout window.
5. Assert rst while in WAIT_DATA with 2 words queued: next edge gives bus = 0, in_ready = 1, busy = 0, tok_count = 0, and the queued words never appear.
6. Preload tok_count to 16'hFFFF by completing 65535 tokens (or via force), then complete one more token: tok_count = 16'h0000 with no error.
